// File: rtl/comm_pkg.sv
// Shared types and constants for the comm_master UART command link.
// Optional stop-bit framing check is enabled by COMM_MASTER_FRAME_CHECK_EN.
package comm_pkg;

  localparam int DEFAULT_BAUD_CNT = 2604;
  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS       = 10;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HIGH = 2'd1,
    TX_LOW  = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // 8N1 frame, transmitted from bit 0 upward: start, data LSB first, stop.
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DATA_BITS-1:0] b);
    return {1'b1, b, 1'b0};
  endfunction

endpackage

// File: rtl/comm_master_uart_rx.sv
// UART receiver: 2-flop RX synchronizer plus 8N1 receive FSM.
// With COMM_MASTER_FRAME_CHECK_EN defined, frames with a 0 stop bit are dropped.
module uart_rx
  import comm_pkg::*;
#(
  parameter int BAUD_CNT = DEFAULT_BAUD_CNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 ready
);

  localparam int BW = $clog2(BAUD_CNT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_CNT / 2 - 1);

  logic [1:0]           sync;
  logic                 rx_s;
  rx_state_t            state;
  logic [BW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '1;
      state    <= RX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      data     <= '0;
      ready    <= 1'b0;
    end else begin
      sync  <= {sync[0], rx};
      ready <= 1'b0;
      case (state)
        RX_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) state <= RX_START;
        end
        // Half-bit delay puts every later sample near the bit centre.
        RX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 4'(DATA_BITS - 1)) state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= RX_IDLE;
`ifdef COMM_MASTER_FRAME_CHECK_EN
            if (rx_s) begin
              data  <= shift;
              ready <= 1'b1;
            end
`else
            data  <= shift;
            ready <= 1'b1;
`endif
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/comm_master.sv
// Host-side UART command master: sends a 16-bit command as two 8N1 bytes
// (high first) and receives response bytes. Macro: COMM_MASTER_FRAME_CHECK_EN.
module comm_master
  import comm_pkg::*;
#(
  parameter int BAUD_CNT = DEFAULT_BAUD_CNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic        TX,
  input  logic        RX,
  output logic        cmd_cmplt,
  output logic [7:0]  resp,
  output logic        resp_cmplt
);

  localparam int BW = $clog2(BAUD_CNT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT - 1);

  tx_state_t             state;
  logic [7:0]            cmd_low;
  logic [FRAME_BITS-1:0] shift;
  logic [BW-1:0]         baud_cnt;
  logic [3:0]            bit_cnt;

  // shift[0] is always the bit currently on TX; the high byte is loaded at
  // acceptance so only the low byte needs to be held for later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      cmd_low   <= '0;
      shift     <= '1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      TX        <= 1'b1;
      cmd_cmplt <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          TX <= 1'b1;
          if (snd_cmd) begin
            cmd_low   <= cmd[7:0];
            cmd_cmplt <= 1'b0;
            shift     <= frame_of(cmd[15:8]);
            TX        <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            state     <= TX_HIGH;
          end
        end
        TX_HIGH, TX_LOW: begin
          if (baud_cnt != BAUD_LAST) begin
            baud_cnt <= baud_cnt + 1'b1;
          end else begin
            baud_cnt <= '0;
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
              bit_cnt <= '0;
              if (state == TX_HIGH) begin
                shift <= frame_of(cmd_low);
                TX    <= 1'b0;
                state <= TX_LOW;
              end else begin
                TX        <= 1'b1;
                cmd_cmplt <= 1'b1;
                state     <= TX_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= {1'b1, shift[FRAME_BITS-1:1]};
              TX      <= shift[1];
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  uart_rx #(
    .BAUD_CNT(BAUD_CNT)
  ) u_rx (
    .clk  (clk),
    .rst  (rst),
    .rx   (RX),
    .data (resp),
    .ready(resp_cmplt)
  );

endmodule

// File: tb/tb_comm_master.sv
// Scoreboard bench for comm_master: TX frames and RX responses are decoded
// by independent monitors and compared against queued expectations.
module tb_comm_master;

  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic        tx;
  logic        rx;
  logic        rx_drv;
  logic        loop;
  logic        cmd_cmplt;
  logic [7:0]  resp;
  logic        resp_cmplt;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic        mon_en;
  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_exp[$];

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comm_master #(.BAUD_CNT(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .snd_cmd   (snd_cmd),
    .cmd       (cmd),
    .TX        (tx),
    .RX        (rx),
    .cmd_cmplt (cmd_cmplt),
    .resp      (resp),
    .resp_cmplt(resp_cmplt)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endfunction

  // TX monitor: a frame is 10 bits, each held constant for exactly B cycles.
  initial begin : tx_mon
    logic [9:0] bits;
    logic       stable;
    logic       v;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en === 1'b1 && rst === 1'b0 && tx === 1'b0) begin
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
          if (i > 0) @(negedge clk);
          v = tx;
          for (int c = 1; c < B; c++) begin
            @(negedge clk);
            if (tx !== v) stable = 1'b0;
          end
          bits[i] = v;
        end
        if (tx_exp.size() == 0) begin
          fail("tx_unexpected_frame");
        end else begin
          e = tx_exp.pop_front();
          check("tx_frame", {22'd0, bits}, {22'd0, 1'b1, e, 1'b0});
          check("tx_bit_width", {31'd0, stable}, 32'd1);
        end
      end
    end
  end

  initial begin : rx_mon
    forever begin
      @(negedge clk);
      if (resp_cmplt === 1'b1) begin
        if (rx_exp.size() == 0) fail("resp_unexpected_pulse");
        else check("resp", {24'd0, resp}, {24'd0, rx_exp.pop_front()});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  // Sends a command; optionally pulses snd_cmd mid-send and/or in the cycle
  // where cmd_cmplt is being set. Both extra pulses must be ignored.
  task automatic send(input logic [15:0] c, input int inject, input logic late);
    int unsigned t0;
    int          n;
    @(posedge clk); #1;
    snd_cmd = 1'b1;
    cmd     = c;
    t0      = cyc;
    tx_exp.push_back(c[15:8]);
    tx_exp.push_back(c[7:0]);
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    cmd     = 16'($urandom);
    check("tx_start_latency", {31'd0, tx}, 32'd0);
    check("cmd_cmplt_cleared", {31'd0, cmd_cmplt}, 32'd0);
    if (inject > 0) begin
      repeat (inject) @(posedge clk);
      #1;
      snd_cmd = 1'b1;
      cmd     = 16'hC5A3;
      @(posedge clk); #1;
      snd_cmd = 1'b0;
    end
    n = 0;
    while (cmd_cmplt !== 1'b1 && n < 30 * B) begin
      snd_cmd = late && (cyc == t0 + 20 * B);
      @(posedge clk); #1;
      n++;
    end
    snd_cmd = 1'b0;
    check("cmd_cmplt_latency", cyc - t0, 20 * B + 1);
    if (late) begin
      repeat (3) @(posedge clk);
      #1;
      check("cmd_cmplt_hold", {31'd0, cmd_cmplt}, 32'd1);
    end
  endtask

  // Drives one RX frame; called and returns at #1 after a rising edge.
  task automatic uart_send(input logic [7:0] b, input logic stop_v);
    logic [9:0] f;
    f = {stop_v, b, 1'b0};
`ifdef COMM_MASTER_FRAME_CHECK_EN
    if (stop_v) rx_exp.push_back(b);
`else
    rx_exp.push_back(b);
`endif
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (B) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [7:0] prev;
    logic [7:0] exp_resp;
    rst     = 1'b1;
    snd_cmd = 1'b0;
    cmd     = '0;
    rx_drv  = 1'b1;
    loop    = 1'b0;
    mon_en  = 1'b1;

    idle(3);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_cmd_cmplt", {31'd0, cmd_cmplt}, 32'd0);
    check("reset_resp", {24'd0, resp}, 32'd0);
    check("reset_resp_cmplt", {31'd0, resp_cmplt}, 32'd0);
    rst = 1'b0;
    idle(4);

    send(16'h4001, 0, 1'b0);
    idle(5);
    send(16'h4001, 100, 1'b1);
    idle(5);

    uart_send(8'hA5, 1'b1);
    uart_send(8'hEE, 1'b1);
    idle(2 * B);

    rx_drv = 1'b0;
    idle(4);
    rx_drv = 1'b1;
    idle(3 * B);

    prev = resp;
    uart_send(8'h3C, 1'b0);
    rx_drv = 1'b1;
    idle(3 * B);
`ifdef COMM_MASTER_FRAME_CHECK_EN
    exp_resp = prev;
`else
    exp_resp = 8'h3C;
`endif
    check("resp_after_bad_stop", {24'd0, resp}, {24'd0, exp_resp});

    fork
      begin
        repeat (4) begin
          send(16'($urandom), 0, 1'b0);
          idle($urandom_range(1, 30));
        end
      end
      begin
        repeat (6) begin
          idle($urandom_range(1, 40));
          uart_send(8'($urandom), 1'b1);
        end
      end
    join
    idle(3 * B);

    loop = 1'b1;
    rx_exp.push_back(8'h01);
    rx_exp.push_back(8'h02);
    send(16'h0102, 0, 1'b0);
    idle(2 * B);
    check("loopback_cmd_cmplt", {31'd0, cmd_cmplt}, 32'd1);
    loop = 1'b0;
    idle(2 * B);

    check("tx_frames_pending", tx_exp.size(), 32'd0);
    check("resp_pending", rx_exp.size(), 32'd0);

    // Reset in the middle of a frame must force TX high on the next cycle.
    mon_en = 1'b0;
    @(posedge clk); #1;
    snd_cmd = 1'b1;
    cmd     = 16'h0000;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    idle(50);
    rst = 1'b1;
    idle(1);
    check("midframe_reset_tx", {31'd0, tx}, 32'd1);
    check("midframe_reset_cmd_cmplt", {31'd0, cmd_cmplt}, 32'd0);
    check("midframe_reset_resp", {24'd0, resp}, 32'd0);
    rst = 1'b0;
    idle(2 * B);
    check("post_reset_tx_idle", {31'd0, tx}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comm_master.md
# comm_master

Host-side UART command master for the logic-analyzer link. It serializes a 16-bit command as two 8N1 UART bytes, high byte first, and deserializes the 8-bit response bytes returned by the device-side UART wrapper. It also raises completion flags for both directions. The block sits in the test/host side of the design and talks to the device only over TX/RX.

## Interface
- BAUD_CNT, 2604, clock cycles per UART bit (≥4).
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- snd_cmd  input  1  start sending `cmd`; sampled only in IDLE.
- cmd  input  16  command word; latched on accepted snd_cmd.
- TX  output  1  serial out to device RX; idle high.
- RX  input  1  serial in from device TX; asynchronous.
- cmd_cmplt  output  1  level; set when both bytes are sent, cleared on the next accepted snd_cmd.
- resp  output  8  last received response byte; held until the next byte.
- resp_cmplt  output  1  one-cycle pulse per received response byte.

## Operation
- **TX states**
  - IDLE: TX=1. On snd_cmd, latch cmd, clear cmd_cmplt, go to HIGH.
  - HIGH: send frame cmd[15:8], then go to LOW.
  - LOW: send frame cmd[7:0], then set cmd_cmplt and go to IDLE.
- **TX frame:** start bit 0, data LSB first, stop bit 1. Each bit lasts exactly BAUD_CNT cycles.
- snd_cmd outside IDLE is ignored. The latched command is unaffected by later cmd changes.
- **RX synchronizer:** RX passes through a 2-flop synchronizer. Both flops reset to 1.
- **RX receiver states** (IDLE, START, DATA, STOP)
  - IDLE: a falling edge (sync=0) enters START.
  - START: wait BAUD_CNT/2 cycles, resample. If the line is 1, it is a false start; return to IDLE with no output.
  - DATA: sample 8 bits at BAUD_CNT intervals, shifting in LSB first.
  - STOP: sample the stop bit, load resp, pulse resp_cmplt, return to IDLE.
- RX and TX are fully independent. The response may arrive while TX is busy. Back-to-back response bytes with no idle gap must all be captured.
- Arithmetic: bit counter is 4 bits; baud counter is $clog2(BAUD_CNT) bits, unsigned, reloaded every bit.

## Timing
- **Reset values:** TX=1, cmd_cmplt=0, resp=8'h00, resp_cmplt=0. All FSMs go to IDLE and counters to 0.
- Reset mid-frame aborts immediately. TX returns high the next cycle.
- The start bit of the high byte appears on TX the cycle after snd_cmd is sampled.
- The low-byte start bit follows the high-byte stop bit with zero gap.
- cmd_cmplt rises 20·BAUD_CNT+1 cycles after snd_cmd is sampled.
- resp_cmplt pulses in the cycle after the stop-bit sample, about 9.5·BAUD_CNT+2 cycles after RX falls at the start bit.
- snd_cmd in the same cycle that cmd_cmplt is being set is ignored.

## Configuration
- COMM_MASTER_FRAME_CHECK_EN
  - Defined: a stop bit sampled as 0 is a framing error. The byte is discarded, resp is unchanged, no resp_cmplt.
  - Undefined: the stop bit is not checked and every frame delivers resp and resp_cmplt.

## Structure
- Shared package comm_pkg:
  - tx_state_t (IDLE/HIGH/LOW) and rx_state_t enums.
  - DEFAULT_BAUD_CNT=2604.
  - DATA_BITS=8 and FRAME_BITS=10 constants.
- One sub-module, uart_rx: synchronizer plus receive FSM, producing a byte and a ready pulse.
- The TX sequencer and shifter stay in comm_master.

## Test plan
- **Reset:** BAUD_CNT=16, hold rst 3 cycles → TX=1, cmd_cmplt=0, resp=0, resp_cmplt=0.
- **Send:** send cmd=16'h4001 → TX shows 0,0x40 LSB-first,1,0,0x01,1 at 16 cycles per bit; cmd_cmplt rises at cycle 321.
- **Busy:** pulse snd_cmd with 16'hC5A3 during an active send → ignored; the original frame is unchanged.
- **Receive:** drive RX frame 0xA5, then 0xEE back-to-back → two resp_cmplt pulses with resp=8'hA5, then 8'hEE.
- **False start:** RX low 4 cycles then high → no resp_cmplt. A stop bit of 0 with FRAME_CHECK_EN → no pulse, resp unchanged.
- **Loopback:** tie TX to RX and send 16'h0102 → resp_cmplt pulses twice with resp 8'h01, then 8'h02; cmd_cmplt=1.
